ps2_host_rx: RTL and testbench

PS/2 host-side receiver: deserialises device-to-host frames (start, 8 data bits LSB first, odd parity, stop) from the PS/2 clock and data lines. It pairs with the host transmitter on the same port. `rx_idle` gates the transmitter's request-to-send, and the transmitter's `tx_idle` drives `rx_en`. Received bytes leave as a one-cycle strobe with data and error flags to the keyboard/mouse front end.

---
 rtl/ps2_pkg.sv | 17 +
 rtl/ps2_clk_filter.sv | 40 ++++
 rtl/ps2_host_rx.sv | 139 +++++++++++++
 tb/tb_ps2_host_rx.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 types, frame constants and parity helper, used by the host receiver and transmitter.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DPS  = 2'd1,
        LOAD = 2'd2
    } ps2_rx_state_t;

    localparam int PS2_FRAME_BITS = 11;

    // Parity bit that makes data plus parity contain an odd number of ones.
    function automatic logic odd_parity(input logic [7:0] data);
        return ~(^data);
    endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// PS/2 clock conditioning: 2-flop synchroniser, FILTER_LEN-sample glitch filter
// and a one-cycle pulse on each falling edge of the filtered clock.
module ps2_clk_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2c_i,
    output logic fall_o
);

    logic [1:0]            sync_q;
    logic [FILTER_LEN-1:0] filt_q, filt_d;
    logic                  fc_q, fc_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            filt_q <= '0;
            fc_q   <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], ps2c_i};
            filt_q <= filt_d;
            fc_q   <= fc_d;
        end
    end

    // The filtered clock only moves once the whole window agrees.
    always_comb begin
        filt_d = {sync_q[1], filt_q[FILTER_LEN-1:1]};
        fc_d   = fc_q;
        if (&filt_q)
            fc_d = 1'b1;
        else if (~|filt_q)
            fc_d = 1'b0;
    end

    assign fall_o = fc_q & ~fc_d;

endmodule

// File: rtl/ps2_host_rx.sv
// PS/2 host receiver: start, 8 data bits LSB first, odd parity, stop.
// Optional watchdog abort of stalled frames is built when PS2RX_WATCHDOG_EN is defined.
module ps2_host_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2c,
    input  logic       ps2d,
    input  logic       rx_en,
    output logic       rx_idle,
    output logic       rx_done_tick,
    output logic [7:0] dout,
    output logic       parity_err,
    output logic       frame_err,
    output logic       timeout_err
);

    localparam int         WD_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [3:0] N_START = 4'(PS2_FRAME_BITS - 2);

    typedef logic [WD_W-1:0] wd_cnt_t;

    ps2_rx_state_t state_q, state_d;
    logic [1:0]    dsync_q;
    logic          ps2d_s;
    logic          fall;
    logic [3:0]    n_q, n_d;
    logic [9:0]    b_q, b_d;
    logic [7:0]    dout_q, dout_d;
    logic          perr_q, perr_d;
    logic          ferr_q, ferr_d;
    logic          load_en;
    logic          wd_expire;

    ps2_clk_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_clk_filter (
        .clk   (clk),
        .reset (reset),
        .ps2c_i(ps2c),
        .fall_o(fall)
    );

    assign ps2d_s  = dsync_q[1];
    assign load_en = (state_q == DPS) && fall && (n_q == 4'd0);

`ifdef PS2RX_WATCHDOG_EN
    wd_cnt_t wd_q, wd_d;

    // Runs only while waiting for edges inside a frame; every edge restarts it.
    assign wd_d      = (state_q == DPS && !fall) ? wd_q + wd_cnt_t'(1) : '0;
    assign wd_expire = (state_q == DPS) && !fall && (wd_q == wd_cnt_t'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            wd_q <= '0;
        else
            wd_q <= wd_d;
    end
`else
    assign wd_expire = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (fall && rx_en && !ps2d_s) state_d = DPS;
            DPS: begin
                if (load_en)
                    state_d = LOAD;
                else if (wd_expire)
                    state_d = IDLE;
            end
            LOAD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rx_idle      = (state_q == IDLE);
        rx_done_tick = (state_q == LOAD);
        timeout_err  = wd_expire;
    end

    // Result registers load on the stop-bit edge so they are valid with the tick.
    always_comb begin
        n_d    = n_q;
        b_d    = b_q;
        dout_d = dout_q;
        perr_d = perr_q;
        ferr_d = ferr_q;
        if (state_q == IDLE && fall && rx_en && !ps2d_s)
            n_d = N_START;
        if (state_q == DPS && fall) begin
            b_d = {ps2d_s, b_q[9:1]};
            if (n_q != 4'd0)
                n_d = n_q - 4'd1;
        end
        if (load_en) begin
            dout_d = b_d[7:0];
            perr_d = (odd_parity(b_d[7:0]) != b_d[8]);
            ferr_d = ~b_d[9];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dsync_q <= 2'b11;
            n_q     <= '0;
            b_q     <= '0;
            dout_q  <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            dsync_q <= {dsync_q[0], ps2d};
            n_q     <= n_d;
            b_q     <= b_d;
            dout_q  <= dout_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
        end
    end

    assign dout       = dout_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;

endmodule

// File: tb/tb_ps2_host_rx.sv
// Scoreboard bench for ps2_host_rx: a PS/2 device model drives frames, a monitor checks each tick.
// Watchdog scenario runs only when PS2RX_WATCHDOG_EN is defined.
module tb_ps2_host_rx;

    localparam int FL   = 8;
    localparam int TO   = 300;
    localparam int HALF = 40;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2c = 1'b1;
    logic       ps2d = 1'b1;
    logic       rx_en = 1'b1;
    logic       rx_idle, rx_done_tick, parity_err, frame_err, timeout_err;
    logic [7:0] dout;

    int         vectors = 0;
    int         miscompares = 0;
    int         tick_cnt = 0;
    int         to_cnt = 0;
    bit         chk_idle = 0;
    bit         wd_expect = 0;
    logic [9:0] sb[$];

    ps2_host_rx #(
        .FILTER_LEN    (FL),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ps2c        (ps2c),
        .ps2d        (ps2d),
        .rx_en       (rx_en),
        .rx_idle     (rx_idle),
        .rx_done_tick(rx_done_tick),
        .dout        (dout),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .timeout_err (timeout_err)
    );

    always #10 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor: pops one scoreboard entry per received byte.
    always @(negedge clk) begin
        if (!reset) begin
            logic [9:0] e;
            if (chk_idle)
                check_eq("rx_idle_after_load", 32'(rx_idle), 32'd1);
            chk_idle = rx_done_tick;
            if (rx_done_tick) begin
                tick_cnt++;
                check_eq("rx_idle_in_load", 32'(rx_idle), 32'd0);
                if (sb.size() == 0) begin
                    check_eq("unexpected_tick", 32'(rx_done_tick), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check_eq("dout", 32'(dout), 32'(e[7:0]));
                    check_eq("parity_err", 32'(parity_err), 32'(e[8]));
                    check_eq("frame_err", 32'(frame_err), 32'(e[9]));
                    $display("rx byte %02h perr %0b ferr %0b (exp %02h %0b %0b) at %0t",
                             dout, parity_err, frame_err, e[7:0], e[8], e[9], $time);
                end
            end
            if (timeout_err) begin
                to_cnt++;
                if (!wd_expect)
                    check_eq("unexpected_timeout", 32'(timeout_err), 32'd0);
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Device model: data changes while clock is high, host samples on the falling edge.
    task automatic send_bits(input logic [10:0] frame, input int nbits,
                             input int glitch_bit, input int drop_bit);
        for (int i = 0; i < nbits; i++) begin
            ps2d = frame[i];
            if (i == drop_bit)
                rx_en = 1'b0;
            if (i == glitch_bit) begin
                wait_clk(20);
                ps2c = 1'b0;
                wait_clk(3);
                ps2c = 1'b1;
                wait_clk(HALF - 23);
            end else begin
                wait_clk(HALF);
            end
            ps2c = 1'b0;
            wait_clk(HALF);
            ps2c = 1'b1;
        end
        ps2d = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                              input int glitch_bit, input int drop_bit);
        logic [10:0] frame;
        frame = {s, p, d, 1'b0};
        sb.push_back({~s, ~(^{p, d}), d});
        $display("tx frame data %02h par %0b stop %0b", d, p, s);
        send_bits(frame, 11, glitch_bit, drop_bit);
        for (int k = 0; k < 100 && sb.size() != 0; k++)
            wait_clk(1);
        if (sb.size() != 0) begin
            check_eq("tick_missing", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        rx_en = 1'b1;
        wait_clk(HALF);
    endtask

    initial begin
        int t0;
        reset = 1'b1;
        wait_clk(3);
        check_eq("rst_rx_idle", 32'(rx_idle), 32'd1);
        check_eq("rst_dout", 32'(dout), 32'd0);
        check_eq("rst_parity_err", 32'(parity_err), 32'd0);
        check_eq("rst_frame_err", 32'(frame_err), 32'd0);
        check_eq("rst_tick", 32'(rx_done_tick), 32'd0);
        check_eq("rst_timeout", 32'(timeout_err), 32'd0);
        reset = 1'b0;
        wait_clk(20);

        send_frame(8'h5A, 1'b1, 1'b1, -1, -1);
        send_frame(8'h5A, 1'b0, 1'b1, -1, -1);
        send_frame(8'hF0, 1'b1, 1'b1, -1, -1);
        send_frame(8'h12, 1'b1, 1'b0, -1, -1);

        // Short low glitch while idle, then one inside a frame.
        ps2c = 1'b0;
        wait_clk(3);
        ps2c = 1'b1;
        wait_clk(20);
        check_eq("idle_glitch_rx_idle", 32'(rx_idle), 32'd1);
        send_frame(8'hAA, 1'b1, 1'b1, 4, -1);

        t0 = tick_cnt;
        rx_en = 1'b0;
        send_bits({1'b1, 1'b1, 8'h33, 1'b0}, 11, -1, -1);
        wait_clk(HALF);
        check_eq("rxen0_no_tick", 32'(tick_cnt), 32'(t0));
        check_eq("rxen0_rx_idle", 32'(rx_idle), 32'd1);
        rx_en = 1'b1;
        wait_clk(HALF);
        send_frame(8'h3C, 1'b1, 1'b1, -1, 5);

`ifdef PS2RX_WATCHDOG_EN
        begin
            int found;
            found = -1;
            t0 = tick_cnt;
            send_bits({1'b1, 1'b0, 8'h1C, 1'b0}, 4, -1, -1);
            ps2d = 1'b1;
            wait_clk(HALF);
            ps2c = 1'b0;
            wd_expect = 1'b1;
            for (int k = 1; k <= TO + 50; k++) begin
                wait_clk(1);
                if (k == HALF)
                    ps2c = 1'b1;
                if (timeout_err && found < 0)
                    found = k;
                if (found >= 0)
                    break;
            end
            $display("watchdog pulse %0d cycles after last pin fall", found);
            check_eq("wd_latency_in_window", 32'(found >= TO + 9 && found <= TO + 12), 32'd1);
            wait_clk(1);
            wd_expect = 1'b0;
            check_eq("wd_rx_idle", 32'(rx_idle), 32'd1);
            check_eq("wd_pulse_count", 32'(to_cnt), 32'd1);
            check_eq("wd_no_tick", 32'(tick_cnt), 32'(t0));
            check_eq("wd_dout_kept", 32'(dout), 32'h3C);
            wait_clk(HALF);
            send_frame(8'h1C, 1'b0, 1'b1, -1, -1);
        end
`endif

        // Reset mid-frame: partial frame lost, outputs back to reset values.
        t0 = tick_cnt;
        send_bits({1'b1, 1'b1, 8'h77, 1'b0}, 5, -1, -1);
        check_eq("midframe_busy", 32'(rx_idle), 32'd0);
        reset = 1'b1;
        #1;
        check_eq("midrst_rx_idle", 32'(rx_idle), 32'd1);
        check_eq("midrst_dout", 32'(dout), 32'd0);
        check_eq("midrst_parity_err", 32'(parity_err), 32'd0);
        check_eq("midrst_frame_err", 32'(frame_err), 32'd0);
        check_eq("midrst_tick", 32'(rx_done_tick), 32'd0);
        wait_clk(3);
        reset = 1'b0;
        wait_clk(HALF);
        check_eq("midrst_no_tick", 32'(tick_cnt), 32'(t0));
        send_frame(8'h1C, 1'b0, 1'b1, -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
